// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, redirect flushes,
// data-memory wait stalls with timeout detection, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} stateT;

    localparam logic [15:0]      TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    stateT       state;
    logic [15:0] waitCnt;
    logic        memBusy;
    logic        lwStall;
    logic        flushApply;

    assign memBusy = MemReqM & ~MemReadyM;
    assign lwStall = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    // Priority: error lock-up, memory wait, redirect, load-use. Everything is forced low during reset.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        flushApply = 1'b0;
        if (rst_n) begin
            if (state == ERR || memBusy) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD     = 1'b1;
                FlushE     = 1'b1;
                flushApply = 1'b1;
            end else if (lwStall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            waitCnt  <= 16'd0;
            MemErr   <= 1'b0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    waitCnt <= 16'd0;
                    if (memBusy) state <= WAIT;
                end
                WAIT: begin
                    if (!memBusy) begin
                        state   <= RUN;
                        waitCnt <= 16'd0;
                    end else if (waitCnt == TIMEOUT_LAST) begin
                        state  <= ERR;
                        MemErr <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
            if (StallF && StallCnt != CNT_MAX) StallCnt <= StallCnt + CNT_ONE;
            if (flushApply && FlushCnt != CNT_MAX) FlushCnt <= FlushCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl, built with a short timeout and narrow
// counters so lock-up and saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;

    localparam int MT = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    Rs1D = '0, Rs2D = '0, RdE = '0;
    logic          ResultSrcE0 = 1'b0, PCSrcE = 1'b0, MemReqM = 1'b0, MemReadyM = 1'b0;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCnt, FlushCnt;
    logic [6:0]    outs;

    int assertCount = 0;
    int failCount   = 0;

    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LW   = 7'b1100010;
    localparam logic [6:0] O_BR   = 7'b0000110;
    localparam logic [6:0] O_MEM  = 7'b1111001;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic br, input logic req, input logic rdy);
        ResultSrcE0 = ld; RdE = rd; Rs1D = r1; Rs2D = r2;
        PCSrcE = br; MemReqM = req; MemReadyM = rdy;
        #2;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        assertCount++;
        if (outs !== O_NONE) begin failCount++; $display("[TB] FAIL reset_outs got %b want %b", outs, O_NONE); end
        tick();
        assertCount++;
        if ({MemErr, StallCnt, FlushCnt} !== {1'b0, 4'd0, 4'd0}) begin
            failCount++; $display("[TB] FAIL reset_regs got %b/%0d/%0d want 0/0/0", MemErr, StallCnt, FlushCnt);
        end
        doReset();
    endtask

    task automatic test_load_use();
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_LW) begin failCount++; $display("[TB] FAIL lw_outs got %b want %b", outs, O_LW); end
        tick();
        applyStimulus(1'b0, 5'd0, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if (StallCnt !== 4'd1) begin failCount++; $display("[TB] FAIL lw_cnt got %0d want 1", StallCnt); end
        assertCount++;
        if (outs !== O_NONE) begin failCount++; $display("[TB] FAIL lw_bubble got %b want %b", outs, O_NONE); end
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_NONE) begin failCount++; $display("[TB] FAIL lw_x0 got %b want %b", outs, O_NONE); end
        tick();
        assertCount++;
        if (StallCnt !== 4'd1) begin failCount++; $display("[TB] FAIL lw_x0_cnt got %0d want 1", StallCnt); end
        applyStimulus(1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_LW) begin failCount++; $display("[TB] FAIL lw_rs1 got %b want %b", outs, O_LW); end
        applyStimulus(1'b0, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_NONE) begin failCount++; $display("[TB] FAIL lw_notload got %b want %b", outs, O_NONE); end
    endtask

    task automatic test_branch();
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_BR) begin failCount++; $display("[TB] FAIL br_outs got %b want %b", outs, O_BR); end
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if ({FlushCnt, StallCnt} !== {4'd1, 4'd1}) begin
            failCount++; $display("[TB] FAIL br_cnt got flush %0d stall %0d want 1 1", FlushCnt, StallCnt);
        end
    endtask

    task automatic test_mem_wait();
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            assertCount++;
            if (outs !== O_MEM) begin failCount++; $display("[TB] FAIL mem_outs%0d got %b want %b", i, outs, O_MEM); end
            tick();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        assertCount++;
        if (outs !== O_NONE) begin failCount++; $display("[TB] FAIL mem_release got %b want %b", outs, O_NONE); end
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if ({MemErr, StallCnt} !== {1'b0, 4'd3}) begin
            failCount++; $display("[TB] FAIL mem_cnt got err %b stall %0d want 0 3", MemErr, StallCnt);
        end
    endtask

    task automatic test_busy_branch();
        doReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
            assertCount++;
            if (outs !== O_MEM) begin failCount++; $display("[TB] FAIL bb_wait%0d got %b want %b", i, outs, O_MEM); end
            tick();
        end
        assertCount++;
        if (FlushCnt !== 4'd0) begin failCount++; $display("[TB] FAIL bb_nocnt got %0d want 0", FlushCnt); end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_BR) begin failCount++; $display("[TB] FAIL bb_flush got %b want %b", outs, O_BR); end
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if ({FlushCnt, StallCnt} !== {4'd1, 4'd2}) begin
            failCount++; $display("[TB] FAIL bb_cnt got flush %0d stall %0d want 1 2", FlushCnt, StallCnt);
        end
    endtask

    task automatic test_timeout();
        doReset();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            assertCount++;
            if (outs !== O_MEM) begin failCount++; $display("[TB] FAIL to_busy%0d got %b want %b", i, outs, O_MEM); end
            tick();
            if (i == MT) begin
                assertCount++;
                if (MemErr !== 1'b0) begin failCount++; $display("[TB] FAIL to_early got %b want 0", MemErr); end
            end
            if (i == MT + 1) begin
                assertCount++;
                if (MemErr !== 1'b1) begin failCount++; $display("[TB] FAIL to_enter got %b want 1", MemErr); end
            end
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
        assertCount++;
        if (outs !== O_MEM) begin failCount++; $display("[TB] FAIL to_stuck got %b want %b", outs, O_MEM); end
        tick();
        assertCount++;
        if ({MemErr, FlushCnt} !== {1'b1, 4'd0}) begin
            failCount++; $display("[TB] FAIL to_sticky got err %b flush %0d want 1 0", MemErr, FlushCnt);
        end
        rst_n = 1'b0;
        #2;
        assertCount++;
        if ({outs, MemErr, StallCnt, FlushCnt} !== {O_NONE, 1'b0, 4'd0, 4'd0}) begin
            failCount++;
            $display("[TB] FAIL to_reset got %b/%b/%0d/%0d want 0000000/0/0/0", outs, MemErr, StallCnt, FlushCnt);
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        assertCount++;
        if (outs !== O_NONE) begin failCount++; $display("[TB] FAIL to_after got %b want %b", outs, O_NONE); end
        tick();
    endtask

    task automatic test_saturation_reset();
        doReset();
        applyStimulus(1'b1, 5'd9, 5'd9, 5'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        assertCount++;
        if (StallCnt !== 4'd15) begin failCount++; $display("[TB] FAIL sat_cnt got %0d want 15", StallCnt); end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        assertCount++;
        if ({outs, StallCnt} !== {O_NONE, 4'd0}) begin
            failCount++; $display("[TB] FAIL midwait_reset got %b/%0d want 0000000/0", outs, StallCnt);
        end
        rst_n = 1'b1;
        // From RUN, four busy edges stay below the timeout; a leftover WAIT count would trip it.
        for (int i = 0; i < 4; i++) tick();
        assertCount++;
        if (MemErr !== 1'b0) begin failCount++; $display("[TB] FAIL midwait_run got %b want 0", MemErr); end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_busy_branch();
        test_timeout();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequential hazard controller for the 5-stage pipeline. It sits beside the forwarding unit and drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers. It resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits, and detects memory timeouts. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive data-memory busy cycles before the error state is entered (legal range 2..65535).
- CNT_W, 16: width of the performance counters.

- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- Rs1D, Rs2D  input  5 each  source registers of the instruction in Decode.
- RdE  input  5  destination register of the instruction in Execute.
- ResultSrcE0  input  1  instruction in Execute is a load.
- PCSrcE  input  1  taken branch/jump resolved in Execute.
- MemReqM  input  1  instruction in Memory accesses data memory.
- MemReadyM  input  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  output  1 each  hold the PC and the D/E/M pipeline registers.
- FlushD, FlushE, FlushW  output  1 each  insert a bubble into the D, E and W pipeline registers.
- MemErr  output  1  sticky memory-timeout flag.
- StallCnt  output  CNT_W  cycles in which StallF was asserted, saturating.
- FlushCnt  output  CNT_W  redirect events taken, saturating.

## Operation
- States: RUN, WAIT, ERR, held in a registered state plus a 16-bit wait_cnt.
- MemBusy = MemReqM & ~MemReadyM.
- lwStall = ResultSrcE0 & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- Priority, highest first: ERR, then MemBusy, then PCSrcE, then lwStall.
- ERR: StallF, StallD, StallE and StallM = 1; FlushW = 1; all other outputs 0. Only reset leaves ERR.
- MemBusy, in RUN or WAIT: StallF, StallD, StallE and StallM = 1; FlushW = 1; FlushD = FlushE = 0. A pending PCSrcE or lwStall is held, because E is frozen, and is acted on after release.
- PCSrcE, not busy: FlushD = FlushE = 1; no stalls. lwStall is ignored because the Decode instruction is on the wrong path.
- lwStall only: StallF = StallD = 1; FlushE = 1.
- Otherwise all Stall* and Flush* outputs = 0.
- Transitions:
  - RUN→WAIT when MemBusy.
  - WAIT→RUN when ~MemBusy.
  - WAIT→ERR when MemBusy and wait_cnt == MEM_TIMEOUT-1.
- wait_cnt: cleared in RUN and on exit from WAIT; increments each WAIT cycle with MemBusy.
- MemErr is set on entry to ERR and cleared only by reset.
- StallCnt increments on each clock edge where StallF = 1. FlushCnt increments on each edge where the PCSrcE flush is applied. Both hold at 2^CNT_W-1.
- A register index of 0 never causes a load-use stall.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, valid in the same cycle as the hazard.
- State, wait_cnt, MemErr and the counters update on the rising clk edge.
- Load-use costs exactly 1 bubble: on the next edge the load moves to M, and lwStall drops because RdE now comes from the bubble.
- Redirect costs 2 bubbles, in D and E, in the cycle PCSrcE = 1.
- Memory wait of N busy cycles gives N stall cycles. Release happens in the cycle MemReadyM = 1, and the pipeline advances on that edge.
- Timeout: the first busy cycle enters WAIT on its edge. ERR is entered on the edge ending busy cycle MEM_TIMEOUT+1, so the outputs show ERR from the following cycle.
- Reset (any time, including mid-WAIT): state = RUN, wait_cnt = 0, MemErr = 0, StallCnt = FlushCnt = 0. While rst_n = 0, all Stall*/Flush* outputs = 0 regardless of inputs.
- Simultaneous MemBusy and PCSrcE: the stall wins. The flush is applied in the first cycle after release if PCSrcE is still 1, and FlushCnt increments only then.

## Test plan
- Load-use: ResultSrcE0 = 1, RdE = 5, Rs2D = 5 for one cycle → StallF = StallD = FlushE = 1 for 1 cycle; StallCnt 0→1; repeat with RdE = 0 → no stall.
- Branch: PCSrcE = 1 while a lwStall condition is also present → FlushD = FlushE = 1, StallF = 0, FlushCnt 0→1.
- Memory wait: MemReqM = 1, MemReadyM = 0 for 3 cycles then 1 → Stall F/D/E/M = 1 and FlushW = 1 for 3 cycles, state back to RUN, StallCnt = 3, MemErr = 0.
- Busy with branch: PCSrcE = 1 throughout a 2-cycle memory wait → no FlushD/FlushE during the wait; both asserted in the release+1 cycle; FlushCnt = 1.
- Timeout: MEM_TIMEOUT = 4, MemBusy held for 10 cycles → state ERR entered on the edge ending the 5th busy cycle; MemErr = 1 and stalls stuck even after MemReadyM = 1; rst_n pulse → all outputs 0, counters 0.
- Saturation and reset: CNT_W = 4, hold lwStall for 20 cycles → StallCnt stops at 15; assert rst_n = 0 mid-WAIT → StallCnt = 0 and state RUN with no clock edge needed.
